min_max_seq: RTL

// Clocked, parametrised successor of the min/max LED bar display.
// - Configuration (mode, min, max, target value) is loaded through a valid/ready handshake.
// - Displayed value ramps one step at a time towards the target.
// - Blink signal for the out-of-value part of the range is generated internally.
// - Registered LED bar output; rejects invalid ranges. Sits between the control/user interface and the LED driver.

---
 rtl/min_max_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/min_max_seq.sv
// Clocked min/max LED bar: config via valid/ready, displayed value ramps towards target,
// internal blink for the part of the range above the current value.
module min_max_seq #(
  parameter int unsigned VALSIZE     = 4,
  parameter int unsigned BLINK_HALF  = 8,
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [1:0]              com_i,
  input  logic [VALSIZE-1:0]      min_i,
  input  logic [VALSIZE-1:0]      max_i,
  input  logic [VALSIZE-1:0]      val_i,
  output logic [2**VALSIZE-1:0]   leds_o,
  output logic [VALSIZE-1:0]      cur_val_o,
  output logic                    settled_o,
  output logic                    cfg_err_o
);

  localparam int unsigned NLED = 2**VALSIZE;
  localparam int unsigned BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned SW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [1:0] COM_RANGE = 2'b00;
  localparam logic [1:0] COM_FROM0 = 2'b01;
  localparam logic [1:0] COM_OFF   = 2'b10;
  localparam logic [1:0] COM_ON    = 2'b11;

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [1:0]          com_q, com_d;
  logic [VALSIZE-1:0]  min_q, min_d;
  logic [VALSIZE-1:0]  max_q, max_d;
  logic [VALSIZE-1:0]  cur_q, cur_d;
  logic [VALSIZE-1:0]  tgt_q, tgt_d;
  logic [SW-1:0]       step_q, step_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic                osc_q, osc_d;
  logic [NLED-1:0]     leds_q, leds_d;
  logic                err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      com_q   <= COM_OFF;
      min_q   <= '0;
      max_q   <= '1;
      cur_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      blink_q <= '0;
      osc_q   <= 1'b1;
      leds_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      com_q   <= com_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      blink_q <= blink_d;
      osc_q   <= osc_d;
      leds_q  <= leds_d;
      err_q   <= err_d;
    end
  end

  // Config acceptance and ramp stepping; requests are only seen in IDLE.
  always_comb begin
    state_d = state_q;
    com_d   = com_q;
    min_d   = min_q;
    max_d   = max_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          if ((com_i == COM_RANGE) && (min_i > max_i)) begin
            err_d = 1'b1;
          end else begin
            com_d  = com_i;
            min_d  = min_i;
            max_d  = max_i;
            tgt_d  = val_i;
            step_d = '0;
            if (val_i != cur_q) state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (step_q == SW'(STEP_CYCLES - 1)) begin
          step_d = '0;
          cur_d  = (tgt_q > cur_q) ? cur_q + VALSIZE'(1) : cur_q - VALSIZE'(1);
          if (cur_d == tgt_q) state_d = IDLE;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running blink, independent of the FSM.
  always_comb begin
    blink_d = blink_q + BW'(1);
    osc_d   = osc_q;
    if (blink_q == BW'(BLINK_HALF - 1)) begin
      blink_d = '0;
      osc_d   = ~osc_q;
    end
  end

  // LED pattern from the registered state; registered once more at the output.
  always_comb begin
    leds_d = '0;
    case (com_q)
      COM_RANGE: begin
        if ((min_q <= cur_q) && (cur_q <= max_q)) begin
          for (int unsigned i = 0; i < NLED; i++) begin
            if ((VALSIZE'(i) >= min_q) && (VALSIZE'(i) <= cur_q)) begin
              leds_d[i] = 1'b1;
            end else if ((VALSIZE'(i) > cur_q) && (VALSIZE'(i) <= max_q)) begin
              leds_d[i] = osc_q;
            end
          end
        end
      end
      COM_FROM0: begin
        for (int unsigned i = 0; i < NLED; i++) begin
          leds_d[i] = (VALSIZE'(i) <= cur_q);
        end
      end
      COM_OFF: leds_d = '0;
      COM_ON:  leds_d = '1;
      default: leds_d = '0;
    endcase
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign settled_o   = (state_q == IDLE);
  assign leds_o      = leds_q;
  assign cur_val_o   = cur_q;
  assign cfg_err_o   = err_q;

endmodule
